// File: rtl/ddr_a2m_burst_addrgen.sv
// Burst address generator: expands an AXI-style burst command into per-beat
// byte addresses, lane strobes, last and error flags.
module ddr_a2m_burst_addrgen #(
  parameter int unsigned P_ADDR_W    = 32,
  parameter int unsigned P_DBYTES    = 16,
  parameter int unsigned P_LG_DBYTES = $clog2(P_DBYTES)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                AXVALID,
  output logic                AXREADY,
  input  logic [P_ADDR_W-1:0] AXADDR,
  input  logic [7:0]          AXLEN,
  input  logic [2:0]          AXSIZE,
  input  logic [1:0]          AXBURST,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [P_ADDR_W-1:0] BADDR,
  output logic [P_DBYTES-1:0] BSTRB,
  output logic                BLAST,
  output logic                BERR
);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic [1:0] {BurstFixed, BurstIncr, BurstWrap} burst_e;

  localparam int unsigned LaneW = (P_LG_DBYTES > 0) ? P_LG_DBYTES : 1;
  localparam logic [P_ADDR_W-1:0] OneA = {{(P_ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  burst_e              mode_q, mode_d;
  logic [P_ADDR_W-1:0] addr_q, addr_d;
  logic [P_ADDR_W-1:0] wmask_q, wmask_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [2:0]          es_q, es_d;
  logic                err_q, err_d;

  logic                busy, last, hs, accept;
  logic                size_err, wrap_req, len_ok, unaligned;
  logic [2:0]          cmd_es;
  logic [P_ADDR_W-1:0] cmd_step, cmd_sm, len_ext;
  logic [P_ADDR_W-1:0] step, sm, next_addr;

  assign busy    = (state_q == StBusy);
  assign last    = (cnt_q == len_q);
  assign hs      = busy && BREADY;
  assign AXREADY = !RST && (!busy || (hs && last));
  assign accept  = AXVALID && AXREADY;

  // Command decode: clamp oversized beats to the bus width.
  assign size_err  = int'(AXSIZE) > int'(P_LG_DBYTES);
  assign cmd_es    = size_err ? 3'(P_LG_DBYTES) : AXSIZE;
  assign cmd_step  = OneA << cmd_es;
  assign cmd_sm    = ~(cmd_step - OneA);
  assign wrap_req  = (AXBURST == 2'd2);
  assign len_ok    = (AXLEN == 8'd1) || (AXLEN == 8'd3) || (AXLEN == 8'd7) || (AXLEN == 8'd15);
  assign unaligned = |(AXADDR & ~cmd_sm);
  assign len_ext   = {{(P_ADDR_W-8){1'b0}}, AXLEN};

  assign step = OneA << es_q;
  assign sm   = ~(step - OneA);

  always_comb begin
    next_addr = addr_q;
    case (mode_q)
      BurstFixed: next_addr = addr_q;
      // Base stays fixed; only the offset inside the wrap window advances.
      BurstWrap:  next_addr = (addr_q & ~wmask_q) | ((addr_q + step) & wmask_q);
      default:    next_addr = (addr_q & sm) + step;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    es_d    = es_q;
    err_d   = err_q;
    if (accept) begin
      state_d = StBusy;
      len_d   = AXLEN;
      cnt_d   = 8'd0;
      es_d    = cmd_es;
      err_d   = size_err || (wrap_req && (!len_ok || unaligned));
      wmask_d = ((len_ext + OneA) << cmd_es) - OneA;
      if (AXBURST == 2'd0) begin
        mode_d = BurstFixed;
        addr_d = AXADDR;
      end else if (wrap_req && len_ok) begin
        mode_d = BurstWrap;
        addr_d = AXADDR & cmd_sm;
      end else begin
        mode_d = BurstIncr;
        addr_d = AXADDR;
      end
    end else if (hs) begin
      if (last) begin
        state_d = StIdle;
      end else begin
        addr_d = next_addr;
        cnt_d  = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      mode_q  <= BurstFixed;
      addr_q  <= '0;
      wmask_q <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      es_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      es_q    <= es_d;
      err_q   <= err_d;
    end
  end

  // Lanes from the byte offset up to the end of the size-aligned beat.
  always_comb begin
    int off, sz, al, hi;
    BSTRB = '0;
    off   = int'(addr_q[LaneW-1:0]) & int'(P_DBYTES - 1);
    sz    = 1 << int'(es_q);
    al    = off & ~(sz - 1);
    hi    = al + sz - 1;
    for (int i = 0; i < int'(P_DBYTES); i++) begin
      if (busy && i >= off && i <= hi) BSTRB[i] = 1'b1;
    end
  end

  assign BVALID = busy;
  assign BADDR  = addr_q;
  assign BLAST  = busy && last;
  assign BERR   = busy && err_q;

endmodule

// File: tb/tb_ddr_a2m_burst_addrgen.sv
// Directed self-checking bench for ddr_a2m_burst_addrgen (32-bit address, 16-byte bus).
module tb_ddr_a2m_burst_addrgen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AXVALID;
  logic        AXREADY;
  logic [31:0] AXADDR;
  logic [7:0]  AXLEN;
  logic [2:0]  AXSIZE;
  logic [1:0]  AXBURST;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] BADDR;
  logic [15:0] BSTRB;
  logic        BLAST;
  logic        BERR;

  int n_checks = 0;
  int n_fail   = 0;

  ddr_a2m_burst_addrgen #(
    .P_ADDR_W   (32),
    .P_DBYTES   (16),
    .P_LG_DBYTES(4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .AXVALID(AXVALID),
    .AXREADY(AXREADY),
    .AXADDR (AXADDR),
    .AXLEN  (AXLEN),
    .AXSIZE (AXSIZE),
    .AXBURST(AXBURST),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .BADDR  (BADDR),
    .BSTRB  (BSTRB),
    .BLAST  (BLAST),
    .BERR   (BERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [15:0] s,
                      input logic l, input logic e);
    chk({tag, ".bvalid"}, 64'(BVALID), 64'd1);
    chk({tag, ".baddr"},  64'(BADDR),  64'(a));
    chk({tag, ".bstrb"},  64'(BSTRB),  64'(s));
    chk({tag, ".blast"},  64'(BLAST),  64'(l));
    chk({tag, ".berr"},   64'(BERR),   64'(e));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents a command from idle; returns one tick after the accepting edge.
  task automatic send(input string tag, input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt);
    AXADDR  = a;
    AXLEN   = len;
    AXSIZE  = sz;
    AXBURST = bt;
    AXVALID = 1'b1;
    #1;
    chk({tag, ".axready"}, 64'(AXREADY), 64'd1);
    step();
    AXVALID = 1'b0;
  endtask

  initial begin
    RST     = 1'b1;
    AXVALID = 1'b0;
    AXADDR  = '0;
    AXLEN   = '0;
    AXSIZE  = '0;
    AXBURST = '0;
    BREADY  = 1'b1;
    #12;
    chk("rst.bvalid",  64'(BVALID),  64'd0);
    chk("rst.axready", 64'(AXREADY), 64'd0);
    chk("rst.baddr",   64'(BADDR),   64'd0);
    chk("rst.bstrb",   64'(BSTRB),   64'd0);
    chk("rst.blast",   64'(BLAST),   64'd0);
    chk("rst.berr",    64'(BERR),    64'd0);
    step();
    RST = 1'b0;

    // INCR, unaligned start
    send("incr", 32'h1003, 8'd2, 3'd2, 2'd1);
    beat("incr.b0", 32'h1003, 16'h0008, 1'b0, 1'b0);
    step();
    beat("incr.b1", 32'h1004, 16'h00F0, 1'b0, 1'b0);
    step();
    beat("incr.b2", 32'h1008, 16'h0F00, 1'b1, 1'b0);
    step();
    chk("incr.idle", 64'(BVALID), 64'd0);

    // WRAP, 4 x 8 bytes
    send("wrap", 32'h1038, 8'd3, 3'd3, 2'd2);
    beat("wrap.b0", 32'h1038, 16'hFF00, 1'b0, 1'b0);
    step();
    beat("wrap.b1", 32'h1020, 16'h00FF, 1'b0, 1'b0);
    step();
    beat("wrap.b2", 32'h1028, 16'hFF00, 1'b0, 1'b0);
    step();
    beat("wrap.b3", 32'h1030, 16'h00FF, 1'b1, 1'b0);
    step();
    chk("wrap.idle", 64'(BVALID), 64'd0);

    // Illegal WRAP length with oversized beat: INCR by 16, error on every beat
    send("ill", 32'h3000, 8'd2, 3'd5, 2'd2);
    beat("ill.b0", 32'h3000, 16'hFFFF, 1'b0, 1'b1);
    step();
    beat("ill.b1", 32'h3010, 16'hFFFF, 1'b0, 1'b1);
    step();
    beat("ill.b2", 32'h3020, 16'hFFFF, 1'b1, 1'b1);
    step();
    chk("ill.idle", 64'(BVALID), 64'd0);

    // Backpressure and back-to-back command
    send("bp", 32'h0100, 8'd1, 3'd2, 2'd1);
    AXADDR  = 32'h2000;
    AXLEN   = 8'd1;
    AXSIZE  = 3'd0;
    AXBURST = 2'd0;
    AXVALID = 1'b1;
    #1;
    chk("bp.b0.axready", 64'(AXREADY), 64'd0);
    beat("bp.b0", 32'h0100, 16'h000F, 1'b0, 1'b0);
    step();
    BREADY = 1'b0;
    #1;
    chk("bp.b1.axready", 64'(AXREADY), 64'd0);
    beat("bp.b1", 32'h0104, 16'h00F0, 1'b1, 1'b0);
    step();
    chk("bp.hold.axready", 64'(AXREADY), 64'd0);
    beat("bp.hold", 32'h0104, 16'h00F0, 1'b1, 1'b0);
    BREADY = 1'b1;
    #1;
    chk("bp.last.axready", 64'(AXREADY), 64'd1);
    step();
    AXVALID = 1'b0;
    beat("b2b.b0", 32'h2000, 16'h0001, 1'b0, 1'b0);
    step();
    beat("b2b.b1", 32'h2000, 16'h0001, 1'b1, 1'b0);
    step();
    chk("b2b.idle", 64'(BVALID), 64'd0);

    // Reset mid-burst, then a single-beat burst
    send("mid", 32'h4000, 8'd7, 3'd2, 2'd1);
    step();
    beat("mid.b1", 32'h4004, 16'h00F0, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk("mid.rst.bvalid",  64'(BVALID),  64'd0);
    chk("mid.rst.baddr",   64'(BADDR),   64'd0);
    chk("mid.rst.axready", 64'(AXREADY), 64'd0);
    step();
    RST = 1'b0;
    #1;
    chk("mid.post.bvalid", 64'(BVALID), 64'd0);
    send("one", 32'h5000, 8'd0, 3'd4, 2'd1);
    beat("one.b0", 32'h5000, 16'hFFFF, 1'b1, 1'b0);
    step();
    chk("one.idle", 64'(BVALID), 64'd0);

    // INCR address wraps modulo 2^32
    send("top", 32'hFFFF_FFF0, 8'd1, 3'd4, 2'd1);
    beat("top.b0", 32'hFFFF_FFF0, 16'hFFFF, 1'b0, 1'b0);
    step();
    beat("top.b1", 32'h0000_0000, 16'hFFFF, 1'b1, 1'b0);
    step();
    chk("top.idle", 64'(BVALID), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_a2m_burst_addrgen.md
DDR_A2M_BURST_ADDRGEN -- requirements
Module: ddr_a2m_burst_addrgen

Interface
REQ-001 Parameter: P_ADDR_W, 32, address width in bits (16..64).
REQ-002 Parameter: P_DBYTES, 16, data-bus width in bytes (power of two, 1..128).
REQ-003 Parameter: P_LG_DBYTES, log2(P_DBYTES), lane-offset width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 CLK  in  1  clock; all state on rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 AXVALID  in  1  burst command valid.
REQ-008 AXREADY  out  1  burst command accepted when AXVALID and AXREADY are high.
REQ-009 AXADDR  in  P_ADDR_W  start byte address.
REQ-010 AXLEN  in  8  beats minus one.
REQ-011 AXSIZE  in  3  log2 bytes per beat.
REQ-012 AXBURST  in  2  burst type: 0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved (treated as INCR).
REQ-013 BVALID  out  1  beat descriptor valid.
REQ-014 BREADY  in  1  beat descriptor consumed when BVALID and BREADY are high.
REQ-015 BADDR  out  P_ADDR_W  beat byte address.
REQ-016 BSTRB  out  P_DBYTES  byte-lane enable for the beat.
REQ-017 BLAST  out  1  final beat of the burst.
REQ-018 BERR  out  1  command was illegal and was corrected; constant for every beat of that burst.

Function
REQ-019 States: IDLE (no burst) and BUSY (a beat is presented on BVALID).
REQ-020 AXREADY = IDLE, or (BUSY and BVALID and BREADY and BLAST); back-to-back bursts have no bubble.
REQ-021 On command accept, the block registers the command and enters BUSY; BVALID goes high the next cycle with beat 0 (latency 1).
REQ-022 Effective size: es = min(AXSIZE, P_LG_DBYTES). AXSIZE > P_LG_DBYTES sets BERR.
REQ-023 Size mask: SM = all ones with the low es bits zero (a parametrised generalisation of the 8-bit size mask).
REQ-024 Beat 0: BADDR = AXADDR unmodified for FIXED and INCR; BADDR = AXADDR and SM for WRAP. An unaligned WRAP start sets BERR.
REQ-025 WRAP with AXLEN not in {1, 3, 7, 15}: BERR = 1 and the burst proceeds as INCR.
REQ-026 Next address, FIXED: BADDR is unchanged for all beats.
REQ-027 Next address, INCR: BADDR_next = (BADDR and SM) + 2^es, computed modulo 2^P_ADDR_W, with no 4KB check.
REQ-028 Next address, WRAP: wrap size W = (AXLEN + 1) * 2^es, base = start and not(W - 1).
REQ-029 WRAP continued: BADDR_next = base + ((BADDR + 2^es) mod W).
REQ-030 BSTRB: let off = BADDR[P_LG_DBYTES-1:0] and al = off and SM. Lanes off through al + 2^es - 1 are 1; all other lanes are 0.
REQ-031 Beat counter, 8 bits: cleared on accept, incremented on each BVALID and BREADY handshake. BLAST = (counter == registered AXLEN).
REQ-032 Beat advance happens only on a BVALID and BREADY handshake. While BREADY is low, BADDR, BSTRB, BLAST and BERR hold stable.
REQ-033 Last-beat handshake with no new command: go to IDLE and drop BVALID the next cycle.
REQ-034 Last-beat handshake with a new command accepted in the same cycle: BVALID stays high and beat 0 of the new burst appears the next cycle.
REQ-035 AXVALID while BUSY (and not on the last-beat handshake) is ignored. AXADDR and the other command fields are don't-care then.
REQ-036 AXLEN = 0: a single beat with BLAST = 1 on beat 0.

Reset
REQ-037 While RST is high, and immediately on its assertion: state = IDLE, BVALID = 0, BLAST = 0, BERR = 0, BADDR = 0, BSTRB = 0, counter = 0.
REQ-038 While RST is high, AXREADY = 0.
REQ-039 Reset mid-burst abandons the burst and no further beats are issued.
REQ-040 The first command may be accepted on the first rising edge after RST deasserts.

Verification (P_DBYTES = 16, P_ADDR_W = 32)
REQ-041 INCR, unaligned start: AXADDR = 0x1003, AXLEN = 2, AXSIZE = 2, BREADY = 1.
  -> BADDR 0x1003 / 0x1004 / 0x1008.
  -> BSTRB 0x0008 / 0x00F0 / 0x0F00.
  -> BLAST on beat 2, BERR = 0.
REQ-042 WRAP: AXADDR = 0x1038, AXLEN = 3, AXSIZE = 3.
  -> BADDR 0x1038, 0x1020, 0x1028, 0x1030.
  -> BSTRB 0xFF00, 0x00FF, 0xFF00, 0x00FF.
REQ-043 Illegal WRAP length and oversized beat: AXBURST = 2, AXLEN = 2, AXSIZE = 5.
  -> BERR = 1 on all 3 beats, es = 4, incrementing by 16.
  -> BSTRB = 0xFFFF on all beats.
REQ-044 Backpressure plus back-to-back: BREADY toggles 1-0-1 on a 2-beat INCR, with a second command (FIXED, AXLEN = 1, AXADDR = 0x2000, AXSIZE = 0) held valid.
  -> Outputs are stable while BREADY = 0.
  -> The second command is accepted on the last-beat handshake, with no BVALID gap.
  -> Then BADDR 0x2000 twice and BSTRB 0x0001 twice.
REQ-045 Reset mid-burst: RST is pulsed during beat 1 of an AXLEN = 7 INCR.
  -> BVALID = 0 asynchronously.
  -> A new command after reset starts cleanly at its own beat 0.
REQ-046 INCR address wrap: AXADDR = 0xFFFFFFF0, AXLEN = 1, AXSIZE = 4.
  -> BADDR 0xFFFFFFF0 then 0x00000000, BLAST on beat 1.
